std_cache_axi_responder: RTL and testbench



---
 rtl/std_cache_axi_responder.sv | 211 +++++++++++++++++++++
 tb/tb_std_cache_axi_responder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_cache_axi_responder.sv
// std_cache_axi_responder: AXI4 memory endpoint for L1 data-cache refill and bypass traffic
package std_cache_axi_pkg;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth = 4;
  localparam int unsigned AddrWidth = 64;
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [5:0]           atop;
  } aw_chan_t;
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
  } ar_chan_t;
  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;
  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

module std_cache_axi_responder #(
  parameter type axi_req_t = std_cache_axi_pkg::axi_req_t,
  parameter type axi_rsp_t = std_cache_axi_pkg::axi_rsp_t,
  parameter int unsigned NumWords = 1024,
  parameter int unsigned ReadLatency = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o
);
  localparam int unsigned DW = std_cache_axi_pkg::DataWidth;
  localparam int unsigned AW = std_cache_axi_pkg::AddrWidth;
  localparam int unsigned IW = std_cache_axi_pkg::IdWidth;
  localparam int unsigned OB = $clog2(DW / 8);
  localparam int unsigned XB = $clog2(NumWords);
  localparam int unsigned LW = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP} state_e;

  state_e        state_q, state_d;
  logic          last_was_rd_q, last_was_rd_d;
  logic [IW-1:0] id_q, id_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    burst_q, burst_d;
  logic          atop_q, atop_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [DW-1:0] mem [NumWords];
  logic [XB-1:0] idx;
  logic [AW-1:0] step, bnd, next_addr;
  logic          grant_rd, grant_wr, w_hs;

  assign idx = addr_q[XB+OB-1:OB];
  assign step = AW'(1) << size_q;
  assign bnd = AW'({1'b0, len_q} + 9'd1) * step;
  // FIXED holds, WRAP folds inside the (len+1)*step window, INCR (and reserved) steps forward
  assign next_addr = burst_q == 2'b00 ? addr_q :
                     burst_q == 2'b10 ? (addr_q & ~(bnd - AW'(1))) | ((addr_q + step) & (bnd - AW'(1))) :
                     addr_q + step;
  // on a tie the channel not served last wins; after reset reads win
  assign grant_rd = axi_req_i.ar_valid & (~axi_req_i.aw_valid | ~last_was_rd_q);
  assign grant_wr = axi_req_i.aw_valid & ~grant_rd;
  assign w_hs = state_q == WR_DATA && axi_req_i.w_valid;

  // next-state, captured request fields and all channel outputs
  always_comb begin
    state_d = state_q;
    last_was_rd_d = last_was_rd_q;
    id_d = id_q;
    addr_d = addr_q;
    len_d = len_q;
    size_d = size_q;
    burst_d = burst_q;
    atop_d = atop_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    axi_rsp_o = '0;
    case (state_q)
      IDLE: begin
        axi_rsp_o.ar_ready = grant_rd;
        axi_rsp_o.aw_ready = grant_wr;
        cnt_d = '0;
        if (grant_rd) begin
          id_d = axi_req_i.ar.id;
          addr_d = axi_req_i.ar.addr;
          len_d = axi_req_i.ar.len;
          size_d = axi_req_i.ar.size;
          burst_d = axi_req_i.ar.burst;
          atop_d = 1'b0;
          lat_d = LW'(ReadLatency - 1);
          last_was_rd_d = 1'b1;
          state_d = ReadLatency == 1 ? RD_BURST : RD_WAIT;
        end else if (grant_wr) begin
          id_d = axi_req_i.aw.id;
          addr_d = axi_req_i.aw.addr;
          len_d = axi_req_i.aw.len;
          size_d = axi_req_i.aw.size;
          burst_d = axi_req_i.aw.burst;
          atop_d = |axi_req_i.aw.atop;
          last_was_rd_d = 1'b0;
          state_d = WR_DATA;
        end
      end
      RD_WAIT: begin
        lat_d = lat_q - LW'(1);
        if (lat_q <= LW'(1)) state_d = RD_BURST;
      end
      RD_BURST: begin
        axi_rsp_o.r_valid = 1'b1;
        axi_rsp_o.r.id = id_q;
        axi_rsp_o.r.data = mem[idx];
        axi_rsp_o.r.last = cnt_q == {1'b0, len_q};
        if (axi_req_i.r_ready) begin
          cnt_d = cnt_q + 9'd1;
          addr_d = next_addr;
          if (cnt_q == {1'b0, len_q}) state_d = IDLE;
        end
      end
      WR_DATA: begin
        axi_rsp_o.w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          cnt_d = cnt_q + 9'd1;
          addr_d = next_addr;
          if (axi_req_i.w.last) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        axi_rsp_o.b_valid = 1'b1;
        axi_rsp_o.b.id = id_q;
        axi_rsp_o.b.resp = (atop_q || cnt_q != {1'b0, len_q} + 9'd1) ? 2'b10 : 2'b00;
        if (axi_req_i.b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // control and transaction registers; reset abandons any burst in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_was_rd_q <= 1'b0;
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      atop_q <= 1'b0;
      cnt_q <= '0;
      lat_q <= '0;
    end else begin
      state_q <= state_d;
      last_was_rd_q <= last_was_rd_d;
      id_q <= id_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      burst_q <= burst_d;
      atop_q <= atop_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
    end
  end

  // byte-masked array write; contents survive reset
  always_ff @(posedge clk_i) begin
    if (w_hs)
      for (int i = 0; i < DW / 8; i++)
        if (axi_req_i.w.strb[i]) mem[idx][i*8 +: 8] <= axi_req_i.w.data[i*8 +: 8];
  end
endmodule

// File: tb/tb_std_cache_axi_responder.sv
// tb_std_cache_axi_responder: directed checks of bursts, strobes, arbitration and reset
module tb_std_cache_axi_responder;
  import std_cache_axi_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  axi_req_t req;
  axi_rsp_t rsp;
  int checks = 0;
  int errors = 0;
  logic [63:0] wdata [16];
  logic [7:0]  wstrb [16];
  logic [63:0] rdata [16];
  logic [1:0]  rresp [16];
  logic [15:0] rlast;
  logic [3:0]  rid, bid;
  logic [1:0]  bresp;
  int rlat, rbeats;

  std_cache_axi_responder dut (.clk_i(clk), .rst_ni(rst_ni), .axi_req_i(req), .axi_rsp_o(rsp));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [5:0] atop, input logic [3:0] id, input int nbeats);
    int n;
    @(negedge clk);
    req.aw = '0;
    req.aw.id = id;
    req.aw.addr = addr;
    req.aw.len = len;
    req.aw.size = 3'd3;
    req.aw.burst = burst;
    req.aw.atop = atop;
    req.aw_valid = 1'b1;
    n = 0;
    #1;
    while (!rsp.aw_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!rsp.aw_ready) begin checks++; errors++; $display("FAIL aw_ready timeout got=0 want=1"); end
    @(posedge clk);
    @(negedge clk);
    req.aw_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      req.w.data = wdata[b];
      req.w.strb = wstrb[b];
      req.w.last = (b == nbeats - 1);
      req.w_valid = 1'b1;
      n = 0;
      #1;
      while (!rsp.w_ready && n < 20) begin @(negedge clk); #1; n++; end
      if (!rsp.w_ready) begin checks++; errors++; $display("FAIL w_ready timeout got=0 want=1"); end
      @(posedge clk);
      @(negedge clk);
    end
    req.w_valid = 1'b0;
    req.w.last = 1'b0;
    req.b_ready = 1'b1;
    n = 0;
    #1;
    while (!rsp.b_valid && n < 20) begin @(negedge clk); #1; n++; end
    if (!rsp.b_valid) begin checks++; errors++; $display("FAIL b_valid timeout got=0 want=1"); end
    bresp = rsp.b.resp;
    bid = rsp.b.id;
    @(posedge clk);
    @(negedge clk);
    req.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic lock, input logic [3:0] id);
    int n;
    @(negedge clk);
    req.ar = '0;
    req.ar.id = id;
    req.ar.addr = addr;
    req.ar.len = len;
    req.ar.size = 3'd3;
    req.ar.burst = burst;
    req.ar.lock = lock;
    req.ar_valid = 1'b1;
    req.r_ready = 1'b1;
    n = 0;
    #1;
    while (!rsp.ar_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!rsp.ar_ready) begin checks++; errors++; $display("FAIL ar_ready timeout got=0 want=1"); end
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 1'b0;
    rlat = 1;
    rbeats = 0;
    rlast = '0;
    #1;
    while (!rsp.r_valid && rlat < 20) begin @(negedge clk); #1; rlat++; end
    if (!rsp.r_valid) begin checks++; errors++; $display("FAIL r_valid timeout got=0 want=1"); end
    for (int k = 0; k < 16; k++) begin
      if (!rsp.r_valid) break;
      rdata[k] = rsp.r.data;
      rresp[k] = rsp.r.resp;
      rlast[k] = rsp.r.last;
      rid = rsp.r.id;
      rbeats++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    req.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (rsp !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", rsp); end
  endtask

  task automatic test_incr();
    logic [63:0] exp [4];
    exp[0] = 64'h11; exp[1] = 64'h22; exp[2] = 64'h33; exp[3] = 64'h44;
    for (int k = 0; k < 4; k++) begin wdata[k] = exp[k]; wstrb[k] = 8'hFF; end
    do_write(64'h1000, 8'd3, 2'b01, 6'd0, 4'h3, 4);
    checks++;
    if (bresp !== 2'b00) begin errors++; $display("FAIL incr_bresp got=%0d want=0", bresp); end
    checks++;
    if (bid !== 4'h3) begin errors++; $display("FAIL incr_bid got=%0d want=3", bid); end
    do_read(64'h1000, 8'd3, 2'b01, 1'b0, 4'h5);
    checks++;
    if (rlat !== 2) begin errors++; $display("FAIL incr_latency got=%0d want=2", rlat); end
    checks++;
    if (rbeats !== 4) begin errors++; $display("FAIL incr_beats got=%0d want=4", rbeats); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rdata[k] !== exp[k]) begin errors++; $display("FAIL incr_data beat%0d got=%h want=%h", k, rdata[k], exp[k]); end
    end
    checks++;
    if (rlast !== 16'h0008) begin errors++; $display("FAIL incr_last got=%h want=0008", rlast); end
    checks++;
    if (rid !== 4'h5 || rresp[0] !== 2'b00) begin errors++; $display("FAIL incr_rid_resp got=%0d/%0d want=5/0", rid, rresp[0]); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp [4];
    exp[0] = 64'h33; exp[1] = 64'h44; exp[2] = 64'h11; exp[3] = 64'h22;
    do_read(64'h1010, 8'd3, 2'b10, 1'b0, 4'h1);
    checks++;
    if (rbeats !== 4 || rlast !== 16'h0008) begin errors++; $display("FAIL wrap_beats got=%0d/%h want=4/0008", rbeats, rlast); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rdata[k] !== exp[k]) begin errors++; $display("FAIL wrap_data beat%0d got=%h want=%h", k, rdata[k], exp[k]); end
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp [4];
    int n;
    exp[0] = 64'h11; exp[1] = 64'h22; exp[2] = 64'h33; exp[3] = 64'h44;
    @(negedge clk);
    req.ar = '0;
    req.ar.addr = 64'h1000;
    req.ar.len = 8'd3;
    req.ar.size = 3'd3;
    req.ar.burst = 2'b01;
    req.ar_valid = 1'b1;
    req.r_ready = 1'b1;
    n = 0;
    #1;
    while (!rsp.ar_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 1'b0;
    n = 0;
    #1;
    while (!rsp.r_valid && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (rsp.r_valid !== 1'b1 || rsp.r.data !== exp[0]) begin errors++; $display("FAIL stall_beat0 got=%b/%h want=1/%h", rsp.r_valid, rsp.r.data, exp[0]); end
    @(posedge clk);
    @(negedge clk);
    req.r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rsp.r_valid !== 1'b1 || rsp.r.data !== exp[1]) begin errors++; $display("FAIL stall_hold cyc%0d got=%b/%h want=1/%h", i, rsp.r_valid, rsp.r.data, exp[1]); end
      @(negedge clk);
    end
    req.r_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      checks++;
      if (rsp.r_valid !== 1'b1 || rsp.r.data !== exp[k] || rsp.r.last !== (k == 3)) begin
        errors++;
        $display("FAIL stall_resume beat%0d got=%b/%h/%b want=1/%h/%b", k, rsp.r_valid, rsp.r.data, rsp.r.last, exp[k], k == 3);
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    checks++;
    if (rsp.r_valid !== 1'b0) begin errors++; $display("FAIL stall_end_valid got=%b want=0", rsp.r_valid); end
    req.r_ready = 1'b0;
  endtask

  task automatic test_strobe();
    wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wstrb[0] = 8'hFF;
    do_write(64'h2000, 8'd0, 2'b01, 6'd0, 4'h2, 1);
    wdata[0] = 64'h0;
    wstrb[0] = 8'h0F;
    do_write(64'h2000, 8'd0, 2'b01, 6'd0, 4'h2, 1);
    checks++;
    if (bresp !== 2'b00) begin errors++; $display("FAIL strobe_bresp got=%0d want=0", bresp); end
    do_read(64'h2000, 8'd0, 2'b01, 1'b0, 4'h2);
    checks++;
    if (rdata[0] !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL strobe_data got=%h want=ffffffff00000000", rdata[0]); end
  endtask

  task automatic test_fixed_alias();
    wdata[0] = 64'hA; wstrb[0] = 8'hFF;
    wdata[1] = 64'hB; wstrb[1] = 8'hFF;
    do_write(64'h3000, 8'd1, 2'b00, 6'd0, 4'h4, 2);
    checks++;
    if (bresp !== 2'b00) begin errors++; $display("FAIL fixed_bresp got=%0d want=0", bresp); end
    do_read(64'h1000, 8'd1, 2'b01, 1'b0, 4'h4);
    checks++;
    if (rdata[0] !== 64'hB) begin errors++; $display("FAIL alias_data got=%h want=b", rdata[0]); end
    checks++;
    if (rdata[1] !== 64'h22) begin errors++; $display("FAIL fixed_neighbour got=%h want=22", rdata[1]); end
  endtask

  task automatic test_early_last();
    wdata[0] = 64'hAA; wstrb[0] = 8'hFF;
    wdata[1] = 64'hBB; wstrb[1] = 8'hFF;
    do_write(64'h6100, 8'd3, 2'b01, 6'd0, 4'h6, 2);
    checks++;
    if (bresp !== 2'b10 || bid !== 4'h6) begin errors++; $display("FAIL early_last_b got=%0d/%0d want=2/6", bresp, bid); end
    do_read(64'h6100, 8'd1, 2'b01, 1'b0, 4'h6);
    checks++;
    if (rdata[0] !== 64'hAA || rdata[1] !== 64'hBB) begin errors++; $display("FAIL early_last_data got=%h,%h want=aa,bb", rdata[0], rdata[1]); end
    do_read(64'h6100, 8'd0, 2'b01, 1'b1, 4'h9);
    checks++;
    if (rresp[0] !== 2'b00 || rdata[0] !== 64'hAA) begin errors++; $display("FAIL exclusive_resp got=%0d/%h want=0/aa", rresp[0], rdata[0]); end
    wdata[0] = 64'hCC;
    do_write(64'h6200, 8'd0, 2'b01, 6'h20, 4'h7, 1);
    checks++;
    if (bresp !== 2'b10 || bid !== 4'h7) begin errors++; $display("FAIL atop_b got=%0d/%0d want=2/7", bresp, bid); end
    #1;
    checks++;
    if (rsp.r_valid !== 1'b0 || rsp.b_valid !== 1'b0) begin errors++; $display("FAIL atop_idle got=%b/%b want=0/0", rsp.r_valid, rsp.b_valid); end
  endtask

  task automatic test_arbitration();
    logic exp_rd;
    int n;
    apply_reset();
    wdata[0] = 64'h77;
    for (int r = 0; r < 4; r++) begin
      exp_rd = (r % 2 == 0);
      @(negedge clk);
      req.ar = '0;
      req.ar.id = 4'h1;
      req.ar.addr = 64'h800;
      req.ar.size = 3'd3;
      req.ar.burst = 2'b01;
      req.aw = '0;
      req.aw.id = 4'h2;
      req.aw.addr = 64'h800;
      req.aw.size = 3'd3;
      req.aw.burst = 2'b01;
      req.ar_valid = 1'b1;
      req.aw_valid = 1'b1;
      #1;
      checks++;
      if (rsp.ar_ready !== exp_rd || rsp.aw_ready !== !exp_rd) begin
        errors++;
        $display("FAIL arb_grant round%0d got=ar%b/aw%b want=ar%b/aw%b", r, rsp.ar_ready, rsp.aw_ready, exp_rd, !exp_rd);
      end
      @(posedge clk);
      @(negedge clk);
      req.ar_valid = 1'b0;
      req.aw_valid = 1'b0;
      if (exp_rd) begin
        req.r_ready = 1'b1;
        n = 0;
        #1;
        while (!rsp.r_valid && n < 20) begin @(negedge clk); #1; n++; end
        if (r == 2) begin
          checks++;
          if (rsp.r_valid !== 1'b1 || rsp.r.data !== 64'h77) begin errors++; $display("FAIL arb_readback got=%b/%h want=1/77", rsp.r_valid, rsp.r.data); end
        end
        @(posedge clk);
        @(negedge clk);
        req.r_ready = 1'b0;
      end else begin
        req.w.data = wdata[0];
        req.w.strb = 8'hFF;
        req.w.last = 1'b1;
        req.w_valid = 1'b1;
        n = 0;
        #1;
        while (!rsp.w_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        @(negedge clk);
        req.w_valid = 1'b0;
        req.b_ready = 1'b1;
        n = 0;
        #1;
        while (!rsp.b_valid && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (rsp.b_valid !== 1'b1 || rsp.b.resp !== 2'b00) begin errors++; $display("FAIL arb_write_b got=%b/%0d want=1/0", rsp.b_valid, rsp.b.resp); end
        @(posedge clk);
        @(negedge clk);
        req.b_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    req.ar = '0;
    req.ar.addr = 64'h1000;
    req.ar.len = 8'd3;
    req.ar.size = 3'd3;
    req.ar.burst = 2'b01;
    req.ar_valid = 1'b1;
    req.r_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req.ar_valid = 1'b0;
    n = 0;
    #1;
    while (!rsp.r_valid && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (rsp.r_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre got=%b want=1", rsp.r_valid); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (rsp !== '0) begin errors++; $display("FAIL midreset_outputs got=%h want=0", rsp); end
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    do_read(64'h1008, 8'd0, 2'b01, 1'b0, 4'hA);
    checks++;
    if (rbeats !== 1 || rdata[0] !== 64'h22 || rlat !== 2 || rid !== 4'hA) begin
      errors++;
      $display("FAIL midreset_after got=%0d/%h/%0d/%0d want=1/22/2/10", rbeats, rdata[0], rlat, rid);
    end
  endtask

  initial begin
    req = '0;
    test_reset();
    test_incr();
    test_wrap();
    test_stall();
    test_strobe();
    test_fixed_alias();
    test_early_last();
    test_arbitration();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
